uart_host_receiver: RTL



---
 rtl/uart_host_receiver.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_host_receiver.sv
// UART 8N1 receiver with start/stop validation and a show-ahead byte FIFO.
// Optional even-parity frames (8E1) are enabled by defining UART_RX_PARITY_EN.
module uart_host_receiver #(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int BAUD_RATE       = 115200,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          uart_rx,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          frame_error,
    output logic                          overrun_error,
    output logic                          parity_error,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int CYCLES_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int HALF           = CYCLES_PER_BIT / 2;
    localparam int CNT_W          = $clog2(CYCLES_PER_BIT + 1);
    localparam int PTR_W          = $clog2(FIFO_DEPTH);
    localparam int FCNT_W         = PTR_W + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_HALF  = CNT_W'(HALF - 1);
    localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_t;

    // Even parity holds when data bits and parity bit XOR to zero.
    function automatic logic parity_ok(input logic [7:0] data, input logic par);
        return ~(^data ^ par);
    endfunction

    logic                sync1_r, sync2_r;
    state_t              state_r, state_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic [2:0]          idx_r, idx_s;
    logic [7:0]          shift_r, shift_s;
    logic                push_r, push_s;
    logic                frame_err_r, frame_err_s;
    logic                overrun_r, overrun_s;
    logic [7:0]          mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r, rd_ptr_r;
    logic [FCNT_W-1:0]   count_r;
    logic                pop_s, full_s, wr_en_s;
`ifdef UART_RX_PARITY_EN
    logic                par_r, par_s;
    logic                parity_err_r, parity_err_s;
`endif

    // Two-flop synchronizer for the asynchronous serial line.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= uart_rx;
            sync2_r <= sync1_r;
        end
    end

    // Receiver state register and frame datapath.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            idx_r       <= 3'd0;
            shift_r     <= 8'd0;
            push_r      <= 1'b0;
            frame_err_r <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_r        <= 1'b0;
            parity_err_r <= 1'b0;
`endif
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            idx_r       <= idx_s;
            shift_r     <= shift_s;
            push_r      <= push_s;
            frame_err_r <= frame_err_s;
`ifdef UART_RX_PARITY_EN
            par_r        <= par_s;
            parity_err_r <= parity_err_s;
`endif
        end
    end

    // Next-state logic: bit sampling at mid-bit, stop validation.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r + CNT_W'(1);
        idx_s       = idx_r;
        shift_s     = shift_r;
        push_s      = 1'b0;
        frame_err_s = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_s        = par_r;
        parity_err_s = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                cnt_s = {CNT_W{1'b0}};
                if (!sync2_r) state_s = ST_START;
                else          state_s = ST_IDLE;
            end
            ST_START: begin
                if (cnt_r == CNT_HALF) begin
                    cnt_s = {CNT_W{1'b0}};
                    idx_s = 3'd0;
                    if (sync2_r) state_s = ST_IDLE;
                    else         state_s = ST_DATA;
                end else begin
                    state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_s          = {CNT_W{1'b0}};
                    shift_s[idx_r] = sync2_r;
                    idx_s          = idx_r + 3'd1;
`ifdef UART_RX_PARITY_EN
                    if (idx_r == 3'd7) state_s = ST_PARITY;
`else
                    if (idx_r == 3'd7) state_s = ST_STOP;
`endif
                    else               state_s = ST_DATA;
                end else begin
                    state_s = ST_DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_s   = {CNT_W{1'b0}};
                    par_s   = sync2_r;
                    state_s = ST_STOP;
                end else begin
                    state_s = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_s = {CNT_W{1'b0}};
                    if (sync2_r) begin
                        state_s = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                        if (parity_ok(shift_r, par_r)) push_s       = 1'b1;
                        else                           parity_err_s = 1'b1;
`else
                        push_s = 1'b1;
`endif
                    end else begin
                        frame_err_s = 1'b1;
                        state_s     = ST_BREAK;
                    end
                end else begin
                    state_s = ST_STOP;
                end
            end
            ST_BREAK: begin
                // A held-low line stays here so it reports only one frame error.
                cnt_s = {CNT_W{1'b0}};
                if (sync2_r) state_s = ST_IDLE;
                else         state_s = ST_BREAK;
            end
            default: begin
                cnt_s   = {CNT_W{1'b0}};
                state_s = ST_IDLE;
            end
        endcase
    end

    assign rx_valid  = (count_r != {FCNT_W{1'b0}});
    assign full_s    = (count_r == FIFO_FULL);
    assign pop_s     = rx_valid & rx_ready;
    assign wr_en_s   = push_r & (~full_s | pop_s);
    assign overrun_s = push_r & full_s & ~pop_s;

    // Byte FIFO; a simultaneous pop frees the slot for a push even when full.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r  <= {PTR_W{1'b0}};
            rd_ptr_r  <= {PTR_W{1'b0}};
            count_r   <= {FCNT_W{1'b0}};
            overrun_r <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= 8'd0;
        end else begin
            overrun_r <= overrun_s;
            if (wr_en_s) begin
                mem_r[wr_ptr_r] <= shift_r;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            else       rd_ptr_r <= rd_ptr_r;
            case ({wr_en_s, pop_s})
                2'b10:   count_r <= count_r + FCNT_W'(1);
                2'b01:   count_r <= count_r - FCNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign rx_data       = mem_r[rd_ptr_r];
    assign fifo_count    = count_r;
    assign frame_error   = frame_err_r;
    assign overrun_error = overrun_r;
`ifdef UART_RX_PARITY_EN
    assign parity_error  = parity_err_r;
`else
    assign parity_error  = 1'b0;
`endif

endmodule
